// File: rtl/tsc_ctrl_pkg.sv
// Shared definitions for the TSC multi-cycle control sequencer: state
// encodings, opcode/func constants, instruction classes and the datapath
// select bundle driven during EX/WB.
package tsc_ctrl_pkg;

  // Sequencer state encodings (also exported on state_dbg)
  localparam logic [2:0] ST_IF        = 3'd0;
  localparam logic [2:0] ST_ID        = 3'd1;
  localparam logic [2:0] ST_EX        = 3'd2;
  localparam logic [2:0] ST_WB        = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_STEP_WAIT = 3'd5;

  // Instruction encodings
  localparam logic [3:0] OPCODE_ADI   = 4'd4;
  localparam logic [3:0] OPCODE_LHI   = 4'd6;
  localparam logic [3:0] OPCODE_JMP   = 4'd9;
  localparam logic [3:0] OPCODE_RTYPE = 4'd15;
  localparam logic [5:0] FUNC_ADD     = 6'd0;
  localparam logic [5:0] FUNC_WWD     = 6'd28;

  typedef enum logic [2:0] {
    CLS_ILL = 3'd0,
    CLS_JMP = 3'd1,
    CLS_WWD = 3'd2,
    CLS_ADD = 3'd3,
    CLS_ADI = 3'd4,
    CLS_LHI = 3'd5
  } instr_class_t;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic lhi_sel;
    logic pc_src;
  } sel_t;

  // Instructions that finish in ID (no EX/WB phase)
  function automatic logic is_short(input instr_class_t cls);
    return (cls == CLS_JMP) || (cls == CLS_WWD) || (cls == CLS_ILL);
  endfunction

endpackage

// File: rtl/tsc_ctrl_decode.sv
// Combinational opcode/func decoder: instruction class plus select bundle.
// Ports: i_opcode (IR[15:12]), i_func (IR[5:0]) -> o_cls, o_sel.
// Unsupported opcodes and R-type funcs decode to CLS_ILL with all selects 0.
module tsc_ctrl_decode
  import tsc_ctrl_pkg::*;
(
  input  logic [3:0]   i_opcode,
  input  logic [5:0]   i_func,
  output instr_class_t o_cls,
  output sel_t         o_sel
);

  always_comb begin
    o_cls = CLS_ILL;
    o_sel = '0;
    case (i_opcode)
      OPCODE_JMP: begin
        o_cls        = CLS_JMP;
        o_sel.pc_src = 1'b1;
      end
      OPCODE_ADI: begin
        o_cls         = CLS_ADI;
        o_sel.alu_src = 1'b1;
      end
      OPCODE_LHI: begin
        o_cls         = CLS_LHI;
        o_sel.lhi_sel = 1'b1;
      end
      OPCODE_RTYPE: begin
        if (i_func == FUNC_ADD) begin
          o_cls         = CLS_ADD;
          o_sel.reg_dst = 1'b1;
        end else if (i_func == FUNC_WWD) begin
          o_cls = CLS_WWD;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tsc_mc_control.sv
// Multi-cycle IF/ID/EX/WB control sequencer for the TSC CPU datapath.
// Ports: clk/reset_cpu/cpu_enable, IR fields opcode/func, current pc in;
//        datapath strobes, mux selects, status (stopped, num_inst, state_dbg) out.
// Optional macro TSC_SINGLE_STEP_EN adds step_btn and a STEP_WAIT state.
module tsc_mc_control
  import tsc_ctrl_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int MEM_DEPTH = 46,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_cpu,
  input  logic             cpu_enable,
  input  logic [3:0]       opcode,
  input  logic [5:0]       func,
  input  logic [PC_W-1:0]  pc,
`ifdef TSC_SINGLE_STEP_EN
  input  logic             step_btn,
`endif
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             lhi_sel,
  output logic             wwd_valid,
  output logic             illegal,
  output logic             stopped,
  output logic [CNT_W-1:0] num_inst,
  output logic [2:0]       state_dbg
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [2:0]       w_after_retire;
  logic [CNT_W-1:0] r_num_inst;
  instr_class_t     w_cls;
  sel_t             w_dec_sel;
  sel_t             w_sel;
  logic             w_pc_ovf;
  logic             w_en;
  logic             w_ir_write, w_pc_write, w_reg_write, w_wwd, w_ill;
  logic             w_step_edge;

  tsc_ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_func   (func),
    .o_cls    (w_cls),
    .o_sel    (w_dec_sel)
  );

  // All-ones PC falls out of this compare naturally as overflow
  assign w_pc_ovf = (pc >= PC_W'(MEM_DEPTH));

  // Strobes only fire while enabled and out of reset; selects are pure state decode
  assign w_en = cpu_enable & ~reset_cpu;

`ifdef TSC_SINGLE_STEP_EN
  logic r_step_s1, r_step_s2, r_step_s3;

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
    end else begin
      r_step_s1 <= step_btn;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  // Edge is only consumed in STEP_WAIT; elsewhere it simply expires
  assign w_step_edge    = r_step_s2 & ~r_step_s3;
  assign w_after_retire = ST_STEP_WAIT;
`else
  assign w_step_edge    = 1'b0;
  assign w_after_retire = ST_IF;
`endif

  // Moore output decode
  always_comb begin
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_wwd       = 1'b0;
    w_ill       = 1'b0;
    w_sel       = '0;
    case (r_state)
      ST_IF: w_ir_write = ~w_pc_ovf;
      ST_ID: begin
        w_sel.pc_src = w_dec_sel.pc_src;
        w_pc_write   = is_short(w_cls);
        w_wwd        = (w_cls == CLS_WWD);
        w_ill        = (w_cls == CLS_ILL);
      end
      ST_EX: begin
        w_sel        = w_dec_sel;
        w_sel.pc_src = 1'b0;
      end
      ST_WB: begin
        w_sel        = w_dec_sel;
        w_sel.pc_src = 1'b0;
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IF:        w_next = w_pc_ovf ? ST_STOP : ST_ID;
      ST_ID:        w_next = is_short(w_cls) ? w_after_retire : ST_EX;
      ST_EX:        w_next = ST_WB;
      ST_WB:        w_next = w_after_retire;
      ST_STOP:      w_next = ST_STOP;
`ifdef TSC_SINGLE_STEP_EN
      ST_STEP_WAIT: w_next = w_step_edge ? ST_IF : ST_STEP_WAIT;
`endif
      default:      w_next = ST_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      r_state    <= ST_IF;
      r_num_inst <= '0;
    end else if (cpu_enable) begin
      r_state <= w_next;
      // Retire coincides with every PC update
      if (w_pc_write) r_num_inst <= r_num_inst + CNT_W'(1);
    end
  end

  assign ir_write  = w_ir_write  & w_en;
  assign pc_write  = w_pc_write  & w_en;
  assign reg_write = w_reg_write & w_en;
  assign wwd_valid = w_wwd       & w_en;
  assign illegal   = w_ill       & w_en;
  assign pc_src    = w_sel.pc_src;
  assign reg_dst   = w_sel.reg_dst;
  assign alu_src   = w_sel.alu_src;
  assign lhi_sel   = w_sel.lhi_sel;
  assign stopped   = (r_state == ST_STOP);
  assign num_inst  = r_num_inst;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_tsc_mc_control.sv
module tb_tsc_mc_control;

  localparam int CNT_W = 8;  // small counter so the wrap is reachable quickly

  logic             clk = 1'b0;
  logic             reset_cpu = 1'b1;
  logic             cpu_enable = 1'b1;
  logic [3:0]       opcode = 4'd0;
  logic [5:0]       func = 6'd0;
  logic [15:0]      pc = 16'd0;
  logic             ir_write, pc_write, pc_src, reg_write, reg_dst;
  logic             alu_src, lhi_sel, wwd_valid, illegal, stopped;
  logic [CNT_W-1:0] num_inst;
  logic [2:0]       state_dbg;
`ifdef TSC_SINGLE_STEP_EN
  logic             step_btn = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tsc_mc_control #(.PC_W(16), .MEM_DEPTH(46), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_cpu  (reset_cpu),
    .cpu_enable (cpu_enable),
    .opcode     (opcode),
    .func       (func),
    .pc         (pc),
`ifdef TSC_SINGLE_STEP_EN
    .step_btn   (step_btn),
`endif
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .lhi_sel    (lhi_sel),
    .wwd_valid  (wwd_valid),
    .illegal    (illegal),
    .stopped    (stopped),
    .num_inst   (num_inst),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_cpu = 1'b1;
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_num", 32'(num_inst), 32'd0);
    check("rst_strobes", {27'd0, ir_write, pc_write, reg_write, wwd_valid, illegal}, 32'd0);
    reset_cpu = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();

`ifdef TSC_SINGLE_STEP_EN
    // First instruction runs without a step, then parks in STEP_WAIT
    opcode = 4'd9; func = 6'h13; pc = 16'd0;
    tick(); tick();
    check("ss_first_wait", 32'(state_dbg), 32'd5);
    check("ss_first_num", 32'(num_inst), 32'd1);
    repeat (20) tick();
    check("ss_hold_state", 32'(state_dbg), 32'd5);
    check("ss_hold_num", 32'(num_inst), 32'd1);
    check("ss_hold_strb", {30'd0, ir_write, pc_write}, 32'd0);
    // One press -> exactly one instruction
    step_btn = 1'b1; tick(); tick(); step_btn = 1'b0;
    repeat (10) tick();
    check("ss_one_num", 32'(num_inst), 32'd2);
    check("ss_one_state", 32'(state_dbg), 32'd5);
    // Step an ADD, then press again so the edge lands during EX
    opcode = 4'd15; func = 6'd0;
    step_btn = 1'b1; tick(); tick(); step_btn = 1'b0;
    begin
      int n = 0;
      while (state_dbg != 3'd0 && n < 8) begin tick(); n++; end
      check("ss_reach_if", 32'(state_dbg), 32'd0);
    end
    step_btn = 1'b1;
    tick(); tick();
    check("ss_ex_state", 32'(state_dbg), 32'd2);
    repeat (25) tick();
    step_btn = 1'b0;
    repeat (5) tick();
    check("ss_ex_ign_num", 32'(num_inst), 32'd3);
    check("ss_ex_ign_state", 32'(state_dbg), 32'd5);
`else
    // ADI 0x430F: IF, ID, EX, WB
    opcode = 4'd4; func = 6'h0F; pc = 16'd0;
    check("adi_c1_irw", 32'(ir_write), 32'd1);
    check("adi_c1_state", 32'(state_dbg), 32'd0);
    tick();
    check("adi_c2_id", {28'd0, state_dbg, pc_write}, {28'd0, 3'd1, 1'b0});
    tick();
    check("adi_c3_ex", {26'd0, state_dbg, reg_write, alu_src, reg_dst}, {26'd0, 3'd2, 3'b010});
    tick();
    check("adi_c4_wb", {25'd0, reg_write, pc_write, alu_src, reg_dst, lhi_sel, pc_src, ir_write},
          {25'd0, 7'b1110000});
    tick();
    check("adi_num", 32'(num_inst), 32'd1);
    check("adi_back_if", 32'(state_dbg), 32'd0);

    // JMP 0x9013
    opcode = 4'd9; func = 6'h13; pc = 16'd1;
    tick();
    check("jmp_id", {29'd0, pc_write, pc_src, reg_write}, {29'd0, 3'b110});
    tick();
    check("jmp_num", 32'(num_inst), 32'd2);

    // WWD 0xF01C
    opcode = 4'd15; func = 6'h1C; pc = 16'd2;
    tick();
    check("wwd_id", {29'd0, wwd_valid, pc_write, pc_src}, {29'd0, 3'b110});
    tick();
    check("wwd_pulse_end", {31'd0, wwd_valid}, 32'd0);
    check("wwd_num", 32'(num_inst), 32'd3);

    // ADD 0xF5C0 with enable dropped in EX
    opcode = 4'd15; func = 6'h00; pc = 16'd3;
    tick(); tick();
    check("add_ex", {28'd0, state_dbg, reg_dst}, {28'd0, 3'd2, 1'b1});
    cpu_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("add_frz", {26'd0, state_dbg, reg_write, pc_write, reg_dst}, {26'd0, 3'd2, 3'b001});
    end
    cpu_enable = 1'b1;
    tick();
    check("add_wb", {27'd0, state_dbg, reg_write, reg_dst}, {27'd0, 3'd3, 2'b11});
    tick();
    check("add_num", 32'(num_inst), 32'd4);

    // Unsupported opcode 2
    opcode = 4'd2; func = 6'd0; pc = 16'd4;
    tick();
    check("ill_id", {30'd0, illegal, pc_write}, {30'd0, 2'b11});
    tick();
    check("ill_num", 32'(num_inst), 32'd5);
    check("ill_pulse_end", {31'd0, illegal}, 32'd0);

    // Last valid word at pc=45, then pc=46 overflows
    opcode = 4'd15; func = 6'h1C; pc = 16'd45;
    check("pc45_irw", 32'(ir_write), 32'd1);
    tick();
    check("pc45_wwd", 32'(wwd_valid), 32'd1);
    tick();
    pc = 16'd46;
    #1;
    check("pc46_no_irw", 32'(ir_write), 32'd0);
    tick();
    check("stop_state", {28'd0, state_dbg, stopped}, {28'd0, 3'd4, 1'b1});
    repeat (10) tick();
    check("stop_hold", {27'd0, state_dbg, stopped, pc_write}, {27'd0, 3'd4, 2'b10});
    check("stop_num", 32'(num_inst), 32'd6);
    do_reset();
    check("stop_exit", 32'(stopped), 32'd0);

    // All-ones PC is overflow
    pc = 16'hFFFF;
    #1;
    check("pcff_no_irw", 32'(ir_write), 32'd0);
    tick();
    check("pcff_stop", 32'(stopped), 32'd1);
    do_reset();

    // Counter wrap with JMP-self
    opcode = 4'd9; func = 6'h00; pc = 16'd0;
    for (int i = 0; i < 255; i++) begin tick(); tick(); end
    check("wrap_max", 32'(num_inst), 32'd255);
    tick(); tick();
    check("wrap_zero", 32'(num_inst), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
